lcd_hd44780_bus_ctrl: RTL

Parametrised physical-layer engine for HD44780-class character LCDs. It executes one instruction or data transfer per request in 8-bit or 4-bit bus mode, selectable at run time. Completion is detected either by busy-flag polling with timeout or by a fixed execution delay. It sits between the LCD control sequencer (init, display control, character/CGRAM update) and the bidirectional LCD pins.

---
 rtl/lcd_hd44780_pkg.sv | 35 +++
 rtl/lcd_hd44780_access_cycle.sv | 98 +++++++++
 rtl/lcd_hd44780_bus_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_hd44780_pkg.sv
// Shared types and helpers for the HD44780 bus controller.
// Holds FSM/phase enums, ns-to-cycle conversion and the BF bit index.
package lcd_hd44780_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER_HI,
    ST_XFER_LO,
    ST_POLL_HI,
    ST_POLL_LO,
    ST_EXEC_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EN,
    PH_HOLD,
    PH_GAP
  } phase_e;

  localparam int BF_BIT = 7;

  function automatic int ns_to_cycles(input int ns, input int period);
    int c;
    c = (ns + period - 1) / period;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_hd44780_access_cycle.sv
// One LCD bus access: SETUP -> EN_HIGH -> HOLD -> GAP.
// Ports: i_start/i_rs/i_rw/i_data/i_drive in; o_done, o_rdata, LCD pins out.
module lcd_hd44780_access_cycle
  import lcd_hd44780_pkg::*;
#(
  parameter int N_AS      = 3,
  parameter int N_PW      = 15,
  parameter int N_H       = 1,
  parameter int N_GAP     = 11,
  parameter bit DRIVE_LVL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic [7:0] i_data,
  input  logic       i_drive,
  input  logic [7:0] i_lcd_data,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic [7:0] o_lcd_wdata,
  output logic       o_bidir_sel
);

  localparam int NMAX =
    max_i(max_i(N_AS, N_PW), max_i(N_H, N_GAP));
  localparam int CW = $clog2(NMAX + 1);

  phase_e        r_ph;
  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == '0);
  // Combinational so the next access can start on the same edge.
  assign o_done = (r_ph == PH_GAP) && w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph        <= PH_IDLE;
      r_cnt       <= '0;
      o_rdata     <= '0;
      o_lcd_rs    <= 1'b0;
      o_lcd_rw    <= 1'b0;
      o_lcd_en    <= 1'b0;
      o_lcd_wdata <= '0;
      o_bidir_sel <= ~DRIVE_LVL;
    end else if (i_start) begin
      r_ph        <= PH_SETUP;
      r_cnt       <= CW'(N_AS - 1);
      o_lcd_rs    <= i_rs;
      o_lcd_rw    <= i_rw;
      o_lcd_en    <= 1'b0;
      o_lcd_wdata <= i_data;
      o_bidir_sel <= i_drive ? DRIVE_LVL : ~DRIVE_LVL;
    end else begin
      unique case (r_ph)
        PH_SETUP: begin
          if (w_last) begin
            r_ph     <= PH_EN;
            r_cnt    <= CW'(N_PW - 1);
            o_lcd_en <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        PH_EN: begin
          if (w_last) begin
            r_ph     <= PH_HOLD;
            r_cnt    <= CW'(N_H - 1);
            o_lcd_en <= 1'b0;
            o_rdata  <= i_lcd_data;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        PH_HOLD: begin
          if (w_last) begin
            r_ph        <= PH_GAP;
            r_cnt       <= CW'(N_GAP - 1);
            o_bidir_sel <= ~DRIVE_LVL;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        PH_GAP: begin
          if (w_last) r_ph <= PH_IDLE;
          else        r_cnt <= r_cnt - 1'b1;
        end
        default: r_ph <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_hd44780_bus_ctrl.sv
// HD44780 physical-layer engine: 8/4-bit transfers, BF poll or fixed wait.
// Ports: request (i_start..i_long_exec), status (o_ready/o_done/o_timeout/o_rdata), LCD pins.
module lcd_hd44780_bus_ctrl
  import lcd_hd44780_pkg::*;
#(
  parameter int G_CLK_PERIOD_NS     = 20,
  parameter int G_T_AS_NS           = 60,
  parameter int G_T_PW_NS           = 300,
  parameter int G_T_H_NS            = 20,
  parameter int G_T_CYCLE_NS        = 600,
  parameter int G_EXEC_SHORT_NS     = 40000,
  parameter int G_EXEC_LONG_NS      = 1640000,
  parameter int G_POLL_MAX          = 4096,
  parameter bit G_BIDIR_DRIVE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic [7:0] i_wdata,
  input  logic       i_bus_4bit,
  input  logic       i_nibble_only,
  input  logic       i_poll_busy,
  input  logic       i_long_exec,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_timeout,
  output logic [7:0] o_rdata,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic [7:0] o_lcd_wdata,
  input  logic [7:0] i_lcd_data,
  output logic       o_bidir_sel
);

  localparam int P      = G_CLK_PERIOD_NS;
  localparam int N_AS   = ns_to_cycles(G_T_AS_NS, P);
  localparam int N_PW   = ns_to_cycles(G_T_PW_NS, P);
  localparam int N_H    = ns_to_cycles(G_T_H_NS, P);
  localparam int N_CYC  = ns_to_cycles(G_T_CYCLE_NS, P);
  localparam int N_GAP  = max_i(1, N_CYC - N_AS - N_PW - N_H);
  localparam int N_EXS  = ns_to_cycles(G_EXEC_SHORT_NS, P);
  localparam int N_EXL  = ns_to_cycles(G_EXEC_LONG_NS, P);
  localparam int EW     = $clog2(max_i(N_EXS, N_EXL) + 1);
  localparam int PW     = $clog2(G_POLL_MAX + 1);

  state_e        r_state;
  logic          r_rs, r_rw, r_4bit, r_nib;
  logic          r_poll, r_long, r_bf;
  logic [7:0]    r_wdata;
  logic [3:0]    r_hi;
  logic [PW-1:0] r_pcnt;
  logic [EW-1:0] r_wait;

  state_e     w_nxt;
  logic       w_accept, w_go, w_rs, w_rw, w_drv;
  logic [7:0] w_dat;
  logic       w_fin, w_eval, w_bf, w_hit, w_tmo;
  logic       w_acc_done;
  logic [7:0] w_acc_rdata;

  assign o_ready  = (r_state == ST_IDLE) && !rst;
  assign w_accept = i_start && o_ready;

  always_comb begin
    w_nxt  = r_state;
    w_go   = 1'b0;
    // Defaults describe a busy-flag read: RS=0, RW=1, bus released.
    w_rs   = 1'b0;
    w_rw   = 1'b1;
    w_dat  = '0;
    w_drv  = 1'b0;
    w_fin  = 1'b0;
    w_eval = 1'b0;
    w_bf   = r_bf;
    w_hit  = 1'b0;
    w_tmo  = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_accept) begin
        w_nxt = ST_XFER_HI;
        w_go  = 1'b1;
        w_rs  = i_rs;
        w_rw  = i_rw;
        w_dat = i_bus_4bit ? {i_wdata[7:4], 4'h0} : i_wdata;
        w_drv = ~i_rw;
      end
      ST_XFER_HI: if (w_acc_done) begin
        if (r_4bit && !r_nib) begin
          w_nxt = ST_XFER_LO;
          w_go  = 1'b1;
          w_rs  = r_rs;
          w_rw  = r_rw;
          w_dat = {r_wdata[3:0], 4'h0};
          w_drv = ~r_rw;
        end else begin
          w_fin = 1'b1;
        end
      end
      ST_XFER_LO: if (w_acc_done) w_fin = 1'b1;
      ST_POLL_HI: if (w_acc_done) begin
        if (r_4bit) begin
          w_nxt = ST_POLL_LO;
          w_go  = 1'b1;
        end else begin
          w_eval = 1'b1;
          w_bf   = w_acc_rdata[BF_BIT];
        end
      end
      ST_POLL_LO: if (w_acc_done) w_eval = 1'b1;
      ST_EXEC_WAIT: if (r_wait == '0) w_nxt = ST_DONE;
      ST_DONE: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
    if (w_fin) begin
      if (r_poll) begin
        w_nxt = ST_POLL_HI;
        w_go  = 1'b1;
      end else begin
        w_nxt = ST_EXEC_WAIT;
      end
    end
    if (w_eval) begin
      if (!w_bf) begin
        w_nxt = ST_DONE;
      end else if (r_pcnt == PW'(G_POLL_MAX - 1)) begin
        w_nxt = ST_DONE;
        w_tmo = 1'b1;
      end else begin
        w_nxt = ST_POLL_HI;
        w_go  = 1'b1;
        w_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      o_rdata   <= '0;
      r_rs      <= 1'b0;
      r_rw      <= 1'b0;
      r_wdata   <= '0;
      r_4bit    <= 1'b0;
      r_nib     <= 1'b0;
      r_poll    <= 1'b0;
      r_long    <= 1'b0;
      r_hi      <= '0;
      r_bf      <= 1'b0;
      r_pcnt    <= '0;
      r_wait    <= '0;
    end else begin
      r_state   <= w_nxt;
      o_done    <= (w_nxt == ST_DONE);
      o_timeout <= w_tmo;
      if (w_accept) begin
        r_rs    <= i_rs;
        r_rw    <= i_rw;
        r_wdata <= i_wdata;
        r_4bit  <= i_bus_4bit;
        r_nib   <= i_nibble_only;
        r_poll  <= i_poll_busy;
        r_long  <= i_long_exec;
        r_pcnt  <= '0;
      end
      // Only transfer reads land in o_rdata; busy reads never do.
      if (w_acc_done && r_rw) begin
        if (r_state == ST_XFER_HI) begin
          r_hi <= w_acc_rdata[7:4];
          if (!r_4bit)
            o_rdata <= w_acc_rdata;
          else if (r_nib)
            o_rdata <= {w_acc_rdata[7:4], 4'h0};
        end
        if (r_state == ST_XFER_LO)
          o_rdata <= {r_hi, w_acc_rdata[7:4]};
      end
      if (w_acc_done && r_state == ST_POLL_HI)
        r_bf <= w_acc_rdata[BF_BIT];
      if (w_hit) r_pcnt <= r_pcnt + 1'b1;
      if (w_nxt == ST_EXEC_WAIT && r_state != ST_EXEC_WAIT)
        r_wait <= r_long ? EW'(N_EXL - 1) : EW'(N_EXS - 1);
      else if (r_wait != '0)
        r_wait <= r_wait - 1'b1;
    end
  end

  lcd_hd44780_access_cycle #(
    .N_AS      (N_AS),
    .N_PW      (N_PW),
    .N_H       (N_H),
    .N_GAP     (N_GAP),
    .DRIVE_LVL (G_BIDIR_DRIVE_LEVEL)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_go),
    .i_rs        (w_rs),
    .i_rw        (w_rw),
    .i_data      (w_dat),
    .i_drive     (w_drv),
    .i_lcd_data  (i_lcd_data),
    .o_done      (w_acc_done),
    .o_rdata     (w_acc_rdata),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_rw    (o_lcd_rw),
    .o_lcd_en    (o_lcd_en),
    .o_lcd_wdata (o_lcd_wdata),
    .o_bidir_sel (o_bidir_sel)
  );

endmodule
